// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
//
// Purpose:
//   Multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU. It also
//   handles the MTHI/MTLO writes. One operation is accepted per start pulse
//   while idle. busy stays high for exactly MUL_CYCLES or DIV_CYCLES cycles.
//   HI/LO change only on the completing edge.
//
// Optional feature:
//   MDU_MADD_EN - when defined, opcodes 7..10 (MADD/MADDU/MSUB/MSUBU) add the
//   product to, or subtract it from, {hi,lo}. When undefined they are
//   reserved and no accumulate logic exists.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   EX-stage request, sampled on the rising edge
//   mdop   in   4   operation code (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                   5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU)
//   op1    in  32   rs value (dividend, multiplicand, MT source)
//   op2    in  32   rt value (divisor, multiplier)
//   busy   out  1   operation in flight
//   hi     out 32   HI register
//   lo     out 32   LO register

module mdu_hilo #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic start_mul;
  logic start_div;

  always_comb begin
    start_mul = (mdop == OP_MULT) || (mdop == OP_MULTU);
`ifdef MDU_MADD_EN
    start_mul = start_mul || (mdop == OP_MADD) || (mdop == OP_MADDU) ||
                (mdop == OP_MSUB) || (mdop == OP_MSUBU);
`endif
    start_div = (mdop == OP_DIV) || (mdop == OP_DIVU);
  end

  // ---------------------------------------------------------------------
  // Shared 64-bit multiplier on the latched operands. Signed operations
  // sign-extend both operands to 64 bits. The low 64 bits of that product
  // are then the exact two's-complement result.
  // ---------------------------------------------------------------------
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  always_comb begin
    mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
    mul_signed = mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    mul_a = {{32{mul_signed & a_q[31]}}, a_q};
    mul_b = {{32{mul_signed & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

  // ---------------------------------------------------------------------
  // Shared unsigned divider. For DIV the operands go in as magnitudes and
  // the signs are restored afterwards. This keeps 0x80000000 / -1 well
  // defined: the magnitude 2^31 fits in 32 unsigned bits, and negating
  // the quotient wraps back to 0x80000000 with a zero remainder. A zero
  // divisor is replaced by 1 so simulation never divides by zero. The
  // result is discarded in that case.
  // ---------------------------------------------------------------------
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_mag      = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag      = b_q[31] ? (~b_q + 32'd1) : b_q;
    dvd        = div_signed ? a_mag : a_q;
    dvs        = div_signed ? b_mag : b_q;
    if (dvs == 32'd0) begin
      dvs = 32'd1;
    end
    q_raw = dvd / dvs;
    r_raw = dvd % dvs;
    quo   = q_raw;
    rem   = r_raw;
    if (div_signed) begin
      // Truncation toward zero: the quotient is negative when the operand
      // signs differ, and the remainder follows the dividend.
      if (a_q[31] ^ b_q[31]) begin
        quo = ~q_raw + 32'd1;
      end
      if (a_q[31]) begin
        rem = ~r_raw + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Completion result, as applied to {hi,lo} on the final RUN edge.
  // Accumulating forms read hi/lo as they stand at completion. Nothing
  // writes them during RUN, so this equals their value at launch.
  // ---------------------------------------------------------------------
  logic [63:0] res;
  logic        res_we;

  always_comb begin
    res    = {hi, lo};
    res_we = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res    = prod;
        res_we = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res    = {rem, quo};
        res_we = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        res    = {hi, lo} + prod;
        res_we = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        res    = {hi, lo} - prod;
        res_we = 1'b1;
      end
`endif
      default: begin
        res    = {hi, lo};
        res_we = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM and architectural registers. busy is registered together
  // with state, so it drops on the same edge that writes HI/LO.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= 6'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (mdop == OP_MTHI) begin
              hi <= op1;
            end else if (mdop == OP_MTLO) begin
              lo <= op1;
            end else if (start_mul || start_div) begin
              op_q  <= mdop;
              a_q   <= op1;
              b_q   <= op2;
              count <= start_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // A start request in this state is dropped without latching anything.
          if (count == 6'd1) begin
            count <= 6'd0;
            state <= IDLE;
            busy  <= 1'b0;
            if (res_we) begin
              {hi, lo} <= res;
            end
          end else begin
            count <= count - 6'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo

module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_fail;

  mdu_hilo #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mdop  (mdop),
    .op1   (op1),
    .op2   (op2),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          cyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive a request for exactly one rising edge. Returns #1 after that edge.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = 4'd0;
  endtask

  // Count busy cycles until the first idle cycle, with a bounded wait.
  // Also track whether hi/lo held their pre-operation values.
  task automatic wait_idle(input logic [31:0] h0, input logic [31:0] l0,
                           output int cycles, output bit held);
    cycles = 0;
    held   = 1'b1;
    while (busy && cycles < 100) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int  cycles;
    bit  held;

    n_cmp  = 0;
    n_fail = 0;
    start  = 1'b0;
    mdop   = 4'd0;
    op1    = 32'd0;
    op2    = 32'd0;
    rst_n  = 1'b0;

    // Reset is asynchronous, so outputs are defined before any clock edge.
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //             op     a             b             pre_hi        pre_lo        cyc  exp_hi        exp_lo
    vecs.push_back(vec_t'{4'd1,  32'hFFFFFFFD, 32'h00000005, 32'h00000000, 32'h00000000, 5,  32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back(vec_t'{4'd2,  32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000000, 5,  32'h00000001, 32'hFFFFFFFE});
    vecs.push_back(vec_t'{4'd3,  32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back(vec_t'{4'd4,  32'hFFFFFFFF, 32'h00000010, 32'h00000000, 32'h00000000, 10, 32'h0000000F, 32'h0FFFFFFF});
    vecs.push_back(vec_t'{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000077, 32'h00000088, 10, 32'h00000000, 32'h80000000});
    vecs.push_back(vec_t'{4'd3,  32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 10, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back(vec_t'{4'd3,  32'h00000005, 32'h00000000, 32'h00001234, 32'h0FFFFFFF, 10, 32'h00001234, 32'h0FFFFFFF});
    vecs.push_back(vec_t'{4'd4,  32'h00000009, 32'h00000000, 32'h0000AAAA, 32'h00005555, 10, 32'h0000AAAA, 32'h00005555});
    vecs.push_back(vec_t'{4'd1,  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 5,  32'h40000000, 32'h00000000});
    vecs.push_back(vec_t'{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5,  32'hFFFFFFFE, 32'h00000001});
    vecs.push_back(vec_t'{4'd0,  32'h00000003, 32'h00000004, 32'h00000011, 32'h00000022, 0,  32'h00000011, 32'h00000022});
    vecs.push_back(vec_t'{4'd15, 32'h00000003, 32'h00000004, 32'h00000033, 32'h00000044, 0,  32'h00000033, 32'h00000044});
`ifdef MDU_MADD_EN
    vecs.push_back(vec_t'{4'd7,  32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000A, 5,  32'h00000000, 32'h00000016});
    vecs.push_back(vec_t'{4'd9,  32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000A, 5,  32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back(vec_t'{4'd8,  32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000002, 5,  32'h00000002, 32'h00000000});
    vecs.push_back(vec_t'{4'd10, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 5,  32'hFFFFFFFF, 32'hFFFFFFFF});
`else
    vecs.push_back(vec_t'{4'd7,  32'h00000003, 32'h00000004, 32'h00000055, 32'h00000066, 0,  32'h00000055, 32'h00000066});
    vecs.push_back(vec_t'{4'd10, 32'h00000001, 32'h00000001, 32'h00000055, 32'h00000066, 0,  32'h00000055, 32'h00000066});
`endif

    // Each vector preloads HI/LO with MTHI/MTLO and then launches its
    // operation on the first idle cycle, so back-to-back acceptance is
    // exercised throughout.
    for (int i = 0; i < vecs.size(); i++) begin
      launch(4'd5, vecs[i].pre_hi, 32'd0);
      check($sformatf("vec%0d mthi_busy", i), {63'd0, busy}, 64'd0);
      check($sformatf("vec%0d mthi", i), {32'd0, hi}, {32'd0, vecs[i].pre_hi});
      launch(4'd6, vecs[i].pre_lo, 32'd0);
      check($sformatf("vec%0d mtlo", i), {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(vecs[i].pre_hi, vecs[i].pre_lo, cycles, held);
      check($sformatf("vec%0d busy_cycles", i), 64'(cycles), 64'(vecs[i].cyc));
      check($sformatf("vec%0d hold", i), {63'd0, held}, 64'd1);
      check($sformatf("vec%0d hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // A start during busy is ignored: divide by zero with a MULT pulse inside.
    launch(4'd5, 32'h00001234, 32'd0);
    launch(4'd6, 32'h0FFFFFFF, 32'd0);
    launch(4'd3, 32'h00000005, 32'h00000000);
    cycles = 0;
    held   = 1'b1;
    while (busy && cycles < 100) begin
      if (hi !== 32'h00001234 || lo !== 32'h0FFFFFFF) held = 1'b0;
      cycles++;
      if (cycles == 2) begin
        @(negedge clk);
        start = 1'b1;
        mdop  = 4'd1;
        op1   = 32'd3;
        op2   = 32'd4;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      mdop  = 4'd0;
    end
    check("ignore busy_cycles", 64'(cycles), 64'd10);
    check("ignore hold", {63'd0, held}, 64'd1);
    check("ignore hilo", {hi, lo}, {32'h00001234, 32'h0FFFFFFF});
    repeat (6) @(posedge clk);
    #1;
    check("ignore no_restart", {31'd0, busy, hi}, {32'd0, 32'h00001234});
    check("ignore lo_after", {32'd0, lo}, {32'd0, 32'h0FFFFFFF});

    // Reset in the middle of a MULT: outputs clear without a clock edge,
    // and the abandoned operation never writes HI/LO.
    launch(4'd1, 32'h00000007, 32'h00000009);
    check("rst_mid started", {63'd0, busy}, 64'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid hilo", {hi, lo}, 64'd0);
    check("rst_mid busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid after_hilo", {hi, lo}, 64'd0);
    check("rst_mid after_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the combinational EX-stage ALU and takes the same operand pair.
- Accepts one operation per start pulse and holds busy while it computes.
- The hazard unit stalls any MF/MT/mult/div instruction in ID while busy is high.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..63.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..63.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX-stage request; sampled on the rising edge.
- mdop  in  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 reserved.
- op1  in  32  rs value (dividend, multiplicand, or MT source).
- op2  in  32  rt value (divisor or multiplier).
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: while rst_n=0, asynchronously force hi=0, lo=0, busy=0, FSM=IDLE, counter=0. Reset mid-operation abandons the operation with no HI/LO write.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge T, mdop=MTHI/MTLO:
  - hi (or lo) <= op1 at that edge.
  - busy stays 0; FSM stays IDLE.
- IDLE, start=1, mdop=mult/div op:
  - Operands and op are latched at edge T.
  - counter <= MUL_CYCLES or DIV_CYCLES; FSM goes to RUN.
  - busy=1 during cycles T+1 .. T+N.
- RUN:
  - counter decrements at each edge.
  - At the edge where counter==1: HI/LO are written, FSM goes to IDLE, busy goes to 0.
  - New hi/lo values and busy=0 are visible together in cycle T+N+1.
  - hi/lo keep their old values throughout RUN.
- start while busy=1: ignored entirely; no queueing, and inputs are not latched. The hazard unit guarantees this does not occur. The bench checks that it is ignored.
- start with mdop=NOP or a reserved code: no effect, no busy.
- MULT: signed 32x32 -> 64-bit product; {hi,lo} <= product.
- MULTU: same, unsigned.
- DIV: signed division, quotient truncated toward zero.
  - lo <= quotient; hi <= remainder, with the remainder taking the sign of the dividend.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- DIVU: unsigned division; lo <= quotient, hi <= remainder.
- Divide by zero (op2=0): the full DIV_CYCLES busy period runs, then hi and lo are left unchanged.
- Implementation freedom: the result may be computed at latch time or iteratively. It is observable only at completion, with exact latency N.
- Back-to-back operations: start may be asserted in the first cycle busy=0 after completion, and it is accepted.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: opcodes 7-10 are legal and use MUL_CYCLES. The 64-bit product (signed for 7/9, unsigned for 8/10) is added to or subtracted from {hi,lo} as sampled at completion, modulo 2^64.
- Undefined: opcodes 7-10 are treated as reserved (no effect, no busy), and no accumulate logic is synthesized.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> hi=lo=0 and busy=0 immediately, without a clock edge.
- MULT op1=0xFFFFFFFD (-3), op2=5 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU op1=0xFFFFFFFF, op2=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0xFFFFFFFF/0x10:
  - Expect lo=0x0FFFFFFF, hi=0xF.
  - Then MTHI 0x1234 -> hi=0x1234 the next cycle, busy stays 0.
  - Then DIV by 0 -> busy 10 cycles, hi=0x1234 and lo=0x0FFFFFFF unchanged.
  - Also assert start with MULT during busy -> it is ignored.
- Start MULT, then pull rst_n low at busy cycle 3 -> hi=lo=0 and busy=0; with MDU_MADD_EN defined, preload hi=0, lo=10, then MADD 3*4 -> lo=22, hi=0.
